// File: rtl/pcc_pkg.sv
// -----------------------------------------------------------------------------
// pcc_pkg
//   Shared types and default widths for the pulse_count_capture block.
//   - pcc_state_e : measurement FSM state (IDLE / COUNT / HOLD), 2-bit encoded
//   - PCC_CNT_W, PCC_GATE_W, PCC_SYNC_STAGES : default parameter values
// -----------------------------------------------------------------------------
package pcc_pkg;

  // Default width of the edge accumulator and count_out
  localparam int PCC_CNT_W       = 8;
  // Default width of gate_len / gate timer
  localparam int PCC_GATE_W      = 16;
  // Default depth of the pulse_in synchronizer (must be >= 2)
  localparam int PCC_SYNC_STAGES = 2;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } pcc_state_e;

endpackage : pcc_pkg

// File: rtl/pcc_sync_edge.sv
// -----------------------------------------------------------------------------
// pcc_sync_edge
//   Brings the asynchronous pulse_in pin into the clk domain through a chain of
//   SYNC_STAGES flops and flags each 0->1 transition of the synchronized level
//   as a one-cycle 'rise'.
//
//   Ports:
//     clk    in   clock
//     rst_n  in   reset, synchronous, active-low (clears chain and prev level)
//     pin    in   asynchronous input
//     rise   out  high for one cycle per rising edge of the synchronized pin
//
//   Latency: a pin change sampled at edge k makes 'rise' high during the cycle
//   that ends at edge k+SYNC_STAGES, so a consumer flopping on rise sees the
//   increment SYNC_STAGES+1 cycles after the pin changed.
// -----------------------------------------------------------------------------
module pcc_sync_edge
  import pcc_pkg::*;
#(
  parameter int SYNC_STAGES = PCC_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Next-state for the synchronizer shift chain and the delayed level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and previous-level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Rising edge of the synchronized level; combinational so the counter in the
  // parent consumes it on the very next clock edge.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : pcc_sync_edge

// File: rtl/pulse_count_capture.sv
// -----------------------------------------------------------------------------
// pulse_count_capture
//   Counts rising edges of an asynchronous pin over a programmable gate window
//   of gate_len clk cycles and presents the result through a valid/ack
//   handshake.
//
//   Ports:
//     clk        in   clock
//     rst_n      in   reset, synchronous, active-low; aborts any measurement
//     pulse_in   in   asynchronous input whose rising edges are counted
//     start      in   measurement request, honoured only in IDLE
//     gate_len   in   window length in cycles, captured when start is honoured
//     busy       out  high while counting or holding a result
//     count_vld  out  result valid (HOLD)
//     count_ack  in   result consumed when count_vld & count_ack
//     count_out  out  edge count, stable while count_vld and kept in IDLE
//     overflow   out  accumulator passed its maximum during this measurement
//
//   Build option:
//     PCC_SATURATE_EN  defined   -> count_out sticks at 2^CNT_W-1 on overflow
//                      undefined -> count_out wraps modulo 2^CNT_W
//     overflow is set in both builds.
// -----------------------------------------------------------------------------
module pulse_count_capture
  import pcc_pkg::*;
#(
  parameter int CNT_W       = PCC_CNT_W,
  parameter int GATE_W      = PCC_GATE_W,
  parameter int SYNC_STAGES = PCC_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              count_vld,
  input  logic              count_ack,
  output logic [CNT_W-1:0]  count_out,
  output logic              overflow
);

  pcc_state_e        state_q;
  pcc_state_e        state_d;
  logic [GATE_W-1:0] timer_q;
  logic [GATE_W-1:0] timer_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              busy_q;
  logic              busy_d;
  logic              vld_q;
  logic              vld_d;
  logic              rise;

  pcc_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (pulse_in),
    .rise  (rise)
  );

  // Next-state logic: FSM, gate timer, accumulator and overflow flag
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        // Edges seen in the accept cycle are discarded by the clear below.
        if (start) begin
          timer_d = gate_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          if (gate_len == GATE_W'(0)) begin
            state_d = HOLD;
          end else begin
            state_d = COUNT;
          end
        end else begin
          state_d = IDLE;
        end
      end

      COUNT: begin
        timer_d = timer_q - GATE_W'(1);
        // timer==1 is the last window cycle; its rise is still counted below.
        if (timer_q == GATE_W'(1)) begin
          state_d = HOLD;
        end else begin
          state_d = COUNT;
        end

        if (rise) begin
          if (cnt_q == {CNT_W{1'b1}}) begin
            ovf_d = 1'b1;
`ifdef PCC_SATURATE_EN
            cnt_d = cnt_q;
`else
            cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      HOLD: begin
        // start is deliberately not looked at here, even alongside count_ack.
        if (count_ack) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d != IDLE);
    vld_d  = (state_d == HOLD);
  end

  // State, timer, result and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  assign busy      = busy_q;
  assign count_vld = vld_q;
  assign count_out = cnt_q;
  assign overflow  = ovf_q;

endmodule : pulse_count_capture

// File: tb/tb_pulse_count_capture.sv
// -----------------------------------------------------------------------------
// tb_pulse_count_capture
//   Directed and randomized stimulus for pulse_count_capture. The reference
//   model keeps the pin value seen at every clock edge and counts the 0->1
//   transitions whose synchronized arrival falls inside the gate window.
// -----------------------------------------------------------------------------
module tb_pulse_count_capture;

  localparam int CNT_W   = 8;
  localparam int GATE_W  = 16;
  localparam int S       = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int HIST_N  = 40000;

  logic              clk;
  logic              rst_n;
  logic              pulse_in;
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic              count_vld;
  logic              count_ack;
  logic [CNT_W-1:0]  count_out;
  logic              overflow;

  int checks;
  int errors;
  int cyc;
  bit pin_hist [0:HIST_N-1];

  pulse_count_capture #(
    .CNT_W       (CNT_W),
    .GATE_W      (GATE_W),
    .SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .start     (start),
    .gate_len  (gate_len),
    .busy      (busy),
    .count_vld (count_vld),
    .count_ack (count_ack),
    .count_out (count_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: log the pin value sampled at this edge, then step off the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc < HIST_N) pin_hist[cyc] = pulse_in;
    #1;
  endtask

  // Rising edges sampled at edge k reach the counter at edge k+S; the window
  // covers edges e+1 .. e+glen where e is the accept edge.
  function automatic int model_raw(input int e, input int glen);
    int n;
    n = 0;
    for (int k = e + 1 - S; k <= e + glen - S; k++) begin
      if (k >= 1 && pin_hist[k] && !pin_hist[k-1]) n++;
    end
    return n;
  endfunction

  function automatic int model_cnt(input int n);
`ifdef PCC_SATURATE_EN
    return (n > CNT_MAX) ? CNT_MAX : n;
`else
    return n % (CNT_MAX + 1);
`endif
  endfunction

  // mode 0: npulses single-cycle pulses every 'period' from offset 'first'
  // mode 1: random pin level each cycle
  function automatic logic pin_at(input int r, input int mode, input int first,
                                  input int period, input int npulses);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (r < first) return 1'b0;
    if (((r - first) % period) != 0) return 1'b0;
    return ((r - first) / period) < npulses;
  endfunction

  // Full measurement: accept, drive the window, wait (bounded) for valid,
  // then compare latency, count and overflow against the model.
  task automatic measure(input string tag, input int glen, input int mode, input int first,
                         input int period, input int npulses, output int raw);
    int e;
    int waited;
    gate_len  = GATE_W'(glen);
    start     = 1'b1;
    pulse_in  = 1'b0;
    tick();
    start = 1'b0;
    e     = cyc;
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    check({tag, "_cnt_clr"}, 32'(count_out), 32'd0);
    check({tag, "_ovf_clr"}, 32'(overflow), 32'd0);
    check({tag, "_vld_acc"}, 32'(count_vld), (glen == 0) ? 32'd1 : 32'd0);
    waited = 0;
    while (count_vld !== 1'b1 && waited < glen + 20) begin
      pulse_in = pin_at(cyc + 1 - e, mode, first, period, npulses);
      tick();
      waited++;
    end
    pulse_in = 1'b0;
    check({tag, "_latency"}, 32'(cyc - e), 32'(glen));
    raw = model_raw(e, glen);
    check({tag, "_count"}, 32'(count_out), 32'(model_cnt(raw)));
    check({tag, "_ovf"}, 32'(overflow), (raw > CNT_MAX) ? 32'd1 : 32'd0);
  endtask

  task automatic ack_result(input string tag);
    logic [CNT_W-1:0] co;
    logic             ov;
    co        = count_out;
    ov        = overflow;
    count_ack = 1'b1;
    tick();
    count_ack = 1'b0;
    check({tag, "_vld_drop"}, 32'(count_vld), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    check({tag, "_cnt_keep"}, 32'(count_out), 32'(co));
    check({tag, "_ovf_keep"}, 32'(overflow), 32'(ov));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int raw;
    logic [CNT_W-1:0] co;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    pulse_in  = 1'b0;
    start     = 1'b0;
    gate_len  = '0;
    count_ack = 1'b0;

    // Reset state
    idle(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vld", 32'(count_vld), 32'd0);
    check("rst_cnt", 32'(count_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // 1: 5 pulses, 4 apart, from cycle 2 in a 40-cycle window
    measure("t1", 40, 0, 2, 4, 5, raw);
    check("t1_cnt5", 32'(count_out), 32'd5);
    ack_result("t1");
    idle(4);

    // 2: zero-length window
    measure("t2", 0, 0, 1, 2, 3, raw);
    check("t2_cnt0", 32'(count_out), 32'd0);
    ack_result("t2");
    idle(4);

    // 3: 300 edges at period 2 in a 1000-cycle window
    measure("t3", 1000, 0, 1, 2, 300, raw);
`ifdef PCC_SATURATE_EN
    check("t3_cnt_abs", 32'(count_out), 32'd255);
`else
    check("t3_cnt_abs", 32'(count_out), 32'd44);
`endif
    check("t3_ovf_abs", 32'(overflow), 32'd1);
    ack_result("t3");
    idle(4);

    // 4: stall in HOLD, start ignored, ack+start together, then restart
    measure("t4", 12, 0, 1, 3, 3, raw);
    co = count_out;
    for (int i = 0; i < 20; i++) begin
      start    = (i == 10);
      gate_len = GATE_W'(5);
      pulse_in = 1'($urandom_range(0, 1));
      tick();
      check("t4_hold_vld", 32'(count_vld), 32'd1);
      check("t4_hold_cnt", 32'(count_out), 32'(co));
    end
    start     = 1'b1;
    count_ack = 1'b1;
    pulse_in  = 1'b0;
    tick();
    start     = 1'b0;
    count_ack = 1'b0;
    check("t4_ackstart_busy", 32'(busy), 32'd0);
    check("t4_ackstart_vld", 32'(count_vld), 32'd0);
    idle(4);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_cnt", 32'(count_out), 32'(co));
    measure("t4b", 9, 1, 0, 1, 0, raw);
    ack_result("t4b");
    idle(4);

    // 5: rise arriving in the last window cycle vs one cycle later
    measure("t5a", 10, 0, 10 - S, 2, 1, raw);
    check("t5a_last", 32'(count_out), 32'd1);
    ack_result("t5a");
    idle(4);
    measure("t5b", 10, 0, 10 - S + 1, 2, 1, raw);
    check("t5b_after", 32'(count_out), 32'd0);
    ack_result("t5b");
    idle(4);

    // 6: reset pulse in the middle of COUNT
    gate_len = GATE_W'(50);
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse_in = (i % 2 == 0);
      tick();
    end
    pulse_in = 1'b0;
    idle(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_vld", 32'(count_vld), 32'd0);
    check("t6_cnt", 32'(count_out), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    idle(4);
    measure("t6b", 30, 1, 0, 1, 0, raw);
    ack_result("t6b");
    idle(4);

    // Randomized windows
    for (int t = 0; t < 6; t++) begin
      measure("rnd", int'($urandom_range(0, 60)), 1, 0, 1, 0, raw);
      ack_result("rnd");
      idle(int'($urandom_range(3, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pulse_count_capture
